// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the RAM target: bus widths and FSM state type.
package wb_pkg;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK, HOLD} wb_ram_state_t;
endpackage

// File: rtl/wb_ram_target_if.sv
// Wishbone-classic bus bundle between the arbiter x-side (master) and the RAM target (slave).
interface wb_ram_target_if import wb_pkg::*; #(parameter int WIDTH = 10);
    logic               wb_cyc;
    logic               wb_we;
    logic [WB_SELW-1:0] wb_sel;
    logic [WIDTH-1:0]   wb_adr;
    logic [WB_DW-1:0]   wb_dat;
    logic               wb_ack;
    logic [WB_DW-1:0]   wb_rdt;

    modport master (output wb_cyc, wb_we, wb_sel, wb_adr, wb_dat, input  wb_ack, wb_rdt);
    modport slave  (input  wb_cyc, wb_we, wb_sel, wb_adr, wb_dat, output wb_ack, wb_rdt);
endinterface

// File: rtl/wb_ram_mem.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
module wb_ram_mem import wb_pkg::*; #(
    parameter int WIDTH = 10
) (
    input  logic               wb_clk,
    input  logic [WB_SELW-1:0] we,
    input  logic               re,
    input  logic [WIDTH-1:0]   adr,
    input  logic [WB_DW-1:0]   wdat,
    output logic [WB_DW-1:0]   rdat
);
    logic [WB_DW-1:0] mem [2**WIDTH];

    // NOTE: no reset on the array or read register so the RAM maps onto block memory.
    always_ff @(posedge wb_clk) begin
        for (int i = 0; i < WB_SELW; i++) begin
            if (we[i]) mem[adr][8*i +: 8] <= wdat[8*i +: 8];
        end
        if (re) rdat <= mem[adr];
    end
endmodule

// File: rtl/wb_ram_target.sv
// Wishbone-classic RAM responder: one ack per cyc assertion, waits for cyc low before the next.
// Optional WB_RAM_WAIT_EN stretches ACCESS by WAIT extra cycles.
module wb_ram_target import wb_pkg::*; #(
    parameter int WIDTH = 10,
    parameter int WAIT  = 0
) (
    input  logic           wb_clk,
    input  logic           wb_rst_n,
    wb_ram_target_if.slave bus
);
    localparam logic [3:0] WAIT_CYC = 4'(WAIT);

    wb_ram_state_t      state;
    logic               we_q;
    logic [WB_SELW-1:0] sel_q;
    logic [WIDTH-1:0]   adr_q;
    logic [WB_DW-1:0]   dat_q;
    logic               ack_q;
    logic               last;
    logic               commit;
    logic [WB_DW-1:0]   rdat;

`ifdef WB_RAM_WAIT_EN
    logic [3:0] wait_cnt;
    assign last = (wait_cnt == 4'd0);
`else
    logic unused_wait;
    assign unused_wait = ^WAIT_CYC;
    assign last        = 1'b1;
`endif

    // Gating with live cyc means an abort on the final ACCESS edge leaves memory untouched.
    assign commit = (state == ACCESS) && bus.wb_cyc && last;

    wb_ram_mem #(.WIDTH(WIDTH)) u_mem (
        .wb_clk (wb_clk),
        .we     ({WB_SELW{commit && we_q}} & sel_q),
        .re     (commit && !we_q),
        .adr    (adr_q),
        .wdat   (dat_q),
        .rdat   (rdat)
    );

    assign bus.wb_ack = ack_q;
    assign bus.wb_rdt = (ack_q && !we_q) ? rdat : '0;

    // NOTE: all state here uses <= so every register samples pre-edge values.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            ack_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
`ifdef WB_RAM_WAIT_EN
            wait_cnt <= 4'd0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wb_cyc) begin
                        we_q  <= bus.wb_we;
                        sel_q <= bus.wb_sel;
                        adr_q <= bus.wb_adr;
                        dat_q <= bus.wb_dat;
                        state <= ACCESS;
`ifdef WB_RAM_WAIT_EN
                        wait_cnt <= WAIT_CYC;
`endif
                    end
                end
                ACCESS: begin
                    if (!bus.wb_cyc) begin
                        state <= IDLE;
                    end else if (last) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                    end
`ifdef WB_RAM_WAIT_EN
                    else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
`endif
                end
                ACK:     state <= bus.wb_cyc ? HOLD : IDLE;
                HOLD:    if (!bus.wb_cyc) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_ram_target.sv
// Directed bench for wb_ram_target with a read-data scoreboard and a byte-lane memory model.
module tb_wb_ram_target;
    import wb_pkg::*;

    localparam int WIDTH = 10;
`ifdef WB_RAM_WAIT_EN
    localparam int TB_WAIT = 3;
`else
    localparam int TB_WAIT = 0;
`endif
    localparam int LAT = 2 + TB_WAIT;

    logic wb_clk   = 1'b0;
    logic wb_rst_n = 1'b0;

    wb_ram_target_if #(.WIDTH(WIDTH)) bus ();

    wb_ram_target #(.WIDTH(WIDTH), .WAIT(TB_WAIT)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .bus      (bus.slave)
    );

    always #5 wb_clk = ~wb_clk;

    int checks = 0;
    int passed = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = dat[8*i +: 8];
        return r;
    endfunction

    task automatic drive(input logic we, input logic [3:0] sel, input logic [WIDTH-1:0] adr,
                         input logic [31:0] dat);
        bus.wb_cyc = 1'b1;
        bus.wb_we  = we;
        bus.wb_sel = sel;
        bus.wb_adr = adr;
        bus.wb_dat = dat;
    endtask

    // Full transaction: issue, count cycles to ack, check data, hold cyc, release, check idle.
    task automatic txn(input logic we, input logic [3:0] sel, input logic [WIDTH-1:0] adr,
                       input logic [31:0] dat, input int hold, input string tag);
        int n;
        bit got;
        logic [31:0] exp;
        @(negedge wb_clk);
        drive(we, sel, adr, dat);
        if (we) model[int'(adr)] = merge(model.exists(int'(adr)) ? model[int'(adr)] : 32'h0, dat, sel);
        else exp_q.push_back(model[int'(adr)]);
        n = 0;
        got = 0;
        while (!got && n < LAT + 20) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            n++;
            if (n == 1) begin
                bus.wb_adr = WIDTH'($urandom);
                bus.wb_dat = $urandom;
                bus.wb_sel = 4'($urandom);
            end
            if (bus.wb_ack) got = 1;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        exp = we ? 32'h0 : exp_q.pop_front();
        if (got) check({tag, "_rdt"}, bus.wb_rdt, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            check({tag, "_hold_ack"}, {31'h0, bus.wb_ack}, 32'h0);
            check({tag, "_hold_rdt"}, bus.wb_rdt, 32'h0);
        end
        bus.wb_cyc = 1'b0;
        @(posedge wb_clk);
        @(negedge wb_clk);
        check({tag, "_idle_ack"}, {31'h0, bus.wb_ack}, 32'h0);
        check({tag, "_idle_rdt"}, bus.wb_rdt, 32'h0);
    endtask

    // Drop cyc in the k-th ACCESS cycle; no ack may follow and memory must not change.
    task automatic abort_txn(input logic [WIDTH-1:0] adr, input logic [31:0] dat, input int k,
                             input string tag);
        int acks;
        @(negedge wb_clk);
        drive(1'b1, 4'hF, adr, dat);
        for (int i = 0; i < k; i++) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
        end
        bus.wb_cyc = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            if (bus.wb_ack) acks++;
        end
        check({tag, "_acks"}, 32'(acks), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
        bus.wb_sel = 4'h0;
        bus.wb_adr = '0;
        bus.wb_dat = '0;

        repeat (2) @(negedge wb_clk);
        check("reset_ack", {31'h0, bus.wb_ack}, 32'h0);
        check("reset_rdt", bus.wb_rdt, 32'h0);
        wb_rst_n = 1'b1;

        // Reset asserted mid-ACCESS aborts the write; memory keeps its old word.
        txn(1'b1, 4'hF, 10'h005, 32'hCAFE_F00D, 0, "pre_wr");
        @(negedge wb_clk);
        drive(1'b1, 4'hF, 10'h005, 32'h0BAD_BEEF);
        @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk);
            check("rst_mid_ack", {31'h0, bus.wb_ack}, 32'h0);
        end
        bus.wb_cyc = 1'b0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        txn(1'b0, 4'hF, 10'h005, 32'h0, 0, "rst_rd");

        txn(1'b1, 4'hF, 10'h3FF, 32'hDEAD_BEEF, 0, "top_wr");
        txn(1'b0, 4'hF, 10'h3FF, 32'h0, 0, "top_rd");

        txn(1'b1, 4'hF,    10'h010, 32'h1122_3344, 0, "lane_full");
        txn(1'b1, 4'b0101, 10'h010, 32'hAABB_CCDD, 0, "lane_part");
        txn(1'b0, 4'hF,    10'h010, 32'h0, 0, "lane_rd");
        txn(1'b1, 4'h0,    10'h010, 32'hFFFF_FFFF, 0, "lane_none");
        txn(1'b0, 4'hF,    10'h010, 32'h0, 0, "lane_rd2");

        txn(1'b0, 4'hF, 10'h3FF, 32'h0, 10, "held_rd");
        txn(1'b0, 4'hF, 10'h005, 32'h0, 0, "after_held");

        txn(1'b1, 4'hF, 10'h020, 32'h55AA_55AA, 0, "abort_pre");
        abort_txn(10'h020, 32'h1234_5678, 1, "abort1");
        txn(1'b0, 4'hF, 10'h020, 32'h0, 0, "abort1_rd");
`ifdef WB_RAM_WAIT_EN
        abort_txn(10'h020, 32'h8765_4321, 3, "abort3");
        txn(1'b0, 4'hF, 10'h020, 32'h0, 0, "abort3_rd");
`endif

        for (int i = 0; i < 4; i++) begin
            logic [WIDTH-1:0] a;
            a = WIDTH'($urandom);
            txn(1'b1, 4'hF, a, $urandom, 0, "rnd_wr");
            txn(1'b0, 4'hF, a, 32'h0, 1, "rnd_rd");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
